// File: rtl/wb_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Both wb_scoreboard and wb_port_arbiter import this package.
package wb_pkg;

  localparam int         XLEN_DEFAULT = 32;
  localparam logic [4:0] REG_X0       = 5'd0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_MC   = 2'd2
  } grant_e;

  // One-hot register bit for scoreboard set/clear.
  function automatic logic [31:0] rd_bit(input logic [4:0] rd);
    rd_bit = 32'd1 << rd;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Busy scoreboard and outstanding-operation counter for the multi-cycle unit.
// Holds busy_mask, the outstanding count, mc_issue_ready and the sticky overflow flag.
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue,
  input  logic [4:0]  issue_rd,
  input  logic        accept,
  input  logic [4:0]  accept_rd,
  output logic [31:0] busy_mask,
  output logic        issue_ready
);

  localparam logic [4:0] MAX_CNT = 5'(MAX_OUT);

  logic [4:0]  out_cnt_r;
  logic        err_ovf_r;
  logic        issue_ok_s;
  logic        dec_s;
  logic [4:0]  cnt_next_s;
  logic [31:0] busy_next_s;

  // Next-state for count and mask; a slot freed by an accept this cycle may be reused at once.
  always_comb begin
    issue_ok_s  = issue && (issue_ready || accept);
    dec_s       = accept && (out_cnt_r != 5'd0);
    cnt_next_s  = out_cnt_r;
    busy_next_s = busy_mask;
    if (issue_ok_s && !dec_s) begin
      cnt_next_s = out_cnt_r + 5'd1;
    end else if (!issue_ok_s && dec_s) begin
      cnt_next_s = out_cnt_r - 5'd1;
    end else begin
      cnt_next_s = out_cnt_r;
    end
    busy_next_s = accept ? (busy_next_s & ~rd_bit(accept_rd)) : busy_next_s;
    busy_next_s = (issue_ok_s && (issue_rd != REG_X0)) ? (busy_next_s | rd_bit(issue_rd))
                                                        : busy_next_s;
    busy_next_s[0] = 1'b0;
  end

  // Scoreboard state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_mask   <= 32'd0;
      out_cnt_r   <= 5'd0;
      issue_ready <= 1'b1;
      err_ovf_r   <= 1'b0;
    end else begin
      busy_mask   <= busy_next_s;
      out_cnt_r   <= cnt_next_s;
      issue_ready <= (cnt_next_s < MAX_CNT);
      err_ovf_r   <= err_ovf_r | (issue && !issue_ok_s);
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and the
// multi-cycle unit, pipeline first, with bounded starvation of the multi-cycle side.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_OUT      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_we,
  input  logic [4:0]      pipe_rd,
  input  logic [XLEN-1:0] pipe_wd,
  output logic            pipe_stall,
  input  logic            mc_issue,
  input  logic [4:0]      mc_issue_rd,
  output logic            mc_issue_ready,
  input  logic            mc_valid,
  input  logic [4:0]      mc_rd,
  input  logic [XLEN-1:0] mc_wd,
  output logic            mc_ready,
  output logic [31:0]     busy_mask,
  output logic            rf_we,
  output logic [4:0]      rf_a3,
  output logic [XLEN-1:0] rf_wd3
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  grant_e     grant_s;
  logic [3:0] starve_cnt_r;

  // Grant selection; nothing is granted while reset is asserted.
  always_comb begin
    grant_s = GNT_NONE;
    if (rst) begin
      grant_s = GNT_NONE;
    end else if (mc_valid && (!pipe_we || (starve_cnt_r >= STARVE_MAX))) begin
      grant_s = GNT_MC;
    end else if (pipe_we) begin
      grant_s = GNT_PIPE;
    end else begin
      grant_s = GNT_NONE;
    end
  end

  // Write-port mux and handshake outputs.
  always_comb begin
    rf_a3  = REG_X0;
    rf_wd3 = '0;
    case (grant_s)
      GNT_PIPE: begin
        rf_a3  = pipe_rd;
        rf_wd3 = pipe_wd;
      end
      GNT_MC: begin
        rf_a3  = mc_rd;
        rf_wd3 = mc_wd;
      end
      default: begin
        rf_a3  = REG_X0;
        rf_wd3 = '0;
      end
    endcase
    rf_we      = (grant_s != GNT_NONE) && (rf_a3 != REG_X0);
    mc_ready   = (grant_s == GNT_MC);
    pipe_stall = (grant_s == GNT_MC) && pipe_we;
  end

  // Starvation counter: counts consecutive lost cycles of a pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_r <= 4'd0;
    end else if (!mc_valid || (grant_s == GNT_MC)) begin
      starve_cnt_r <= 4'd0;
    end else if (starve_cnt_r < STARVE_MAX) begin
      starve_cnt_r <= starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  wb_scoreboard #(
    .MAX_OUT(MAX_OUT)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .issue      (mc_issue),
    .issue_rd   (mc_issue_rd),
    .accept     (mc_ready),
    .accept_rd  (mc_rd),
    .busy_mask  (busy_mask),
    .issue_ready(mc_issue_ready)
  );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios with constant
// expectations plus randomized traffic against a behavioural reference model.
module tb_wb_port_arbiter;

  localparam int XLEN = 32;
  localparam int SL   = 4;
  localparam int MO   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            pipe_we = 1'b0, mc_issue = 1'b0, mc_valid = 1'b0;
  logic [4:0]      pipe_rd = 5'd0, mc_issue_rd = 5'd0, mc_rd = 5'd0;
  logic [XLEN-1:0] pipe_wd = '0, mc_wd = '0;
  logic            pipe_stall, mc_issue_ready, mc_ready, rf_we;
  logic [31:0]     busy_mask;
  logic [4:0]      rf_a3;
  logic [XLEN-1:0] rf_wd3;

  int nvec = 0;
  int nerr = 0;

  // reference model state
  int              m_out, m_starve;
  logic [31:0]     m_busy;
  logic            m_ovf;
  logic [XLEN-1:0] m_rf[32];
  logic [XLEN-1:0] b_rf[32];
  // predicted combinational outputs for the current cycle
  logic            e_we, e_mcr, e_stall, e_mcwin;
  logic [4:0]      e_a3;
  logic [XLEN-1:0] e_wd;

  wb_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(SL), .MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd), .pipe_stall(pipe_stall),
    .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd), .mc_issue_ready(mc_issue_ready),
    .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_wd(mc_wd), .mc_ready(mc_ready),
    .busy_mask(busy_mask),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3)
  );

  always #5 clk = ~clk;

  // register file fed by the DUT write port
  always @(posedge clk) if (rf_we) b_rf[rf_a3] <= rf_wd3;

  task automatic model_reset();
    m_out = 0; m_starve = 0; m_busy = 32'd0; m_ovf = 1'b0;
  endtask

  task automatic drive(input logic pw, input logic [4:0] prd, input logic [31:0] pwd,
                       input logic iss, input logic [4:0] ird,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mwd);
    logic pwin;
    pipe_we = pw; pipe_rd = prd; pipe_wd = pwd;
    mc_issue = iss; mc_issue_rd = ird;
    mc_valid = mv; mc_rd = mrd; mc_wd = mwd;
    e_mcwin = !rst && mv && (!pw || m_starve >= SL);
    pwin    = !rst && pw && !e_mcwin;
    e_a3    = e_mcwin ? mrd : (pwin ? prd : 5'd0);
    e_wd    = e_mcwin ? mwd : (pwin ? pwd : 32'd0);
    e_we    = (e_mcwin || pwin) && (e_a3 != 5'd0);
    e_mcr   = e_mcwin;
    e_stall = e_mcwin && pw;
    #3;
  endtask

  task automatic tick();
    logic ok;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      ok = mc_issue && ((m_out < MO) || e_mcwin);
      if (mc_issue && !ok) m_ovf = 1'b1;
      if (e_mcwin) m_busy[mc_rd] = 1'b0;
      if (ok && mc_issue_rd != 5'd0) m_busy[mc_issue_rd] = 1'b1;
      m_out = m_out + (ok ? 1 : 0) - ((e_mcwin && m_out > 0) ? 1 : 0);
      m_starve = (!mc_valid || e_mcwin) ? 0 : ((m_starve < SL) ? m_starve + 1 : SL);
      if (e_we) m_rf[e_a3] = e_wd;
    end
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); tick(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    idle();
    nvec++; if (busy_mask !== 32'd0) begin nerr++; $display("FAIL reset_busy: got %h want 0", busy_mask); end
    nvec++; if (mc_issue_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b want 1", mc_issue_ready); end
    nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL reset_rfwe: got %b want 0", rf_we); end
    nvec++; if (dut.u_sb.out_cnt_r !== 5'd0 || dut.u_sb.err_ovf_r !== 1'b0) begin
      nerr++; $display("FAIL reset_cnt: got cnt=%0d ovf=%b want 0/0", dut.u_sb.out_cnt_r, dut.u_sb.err_ovf_r); end
    tick();
  endtask

  task automatic test_pipe_write();
    drive(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    nvec++; if ({rf_we, rf_a3, rf_wd3} !== {1'b1, 5'd5, 32'h12345678}) begin
      nerr++; $display("FAIL pipe_write: got we=%b a3=%0d wd=%h want 1/5/12345678", rf_we, rf_a3, rf_wd3); end
    tick(); idle();
    nvec++; if (b_rf[5] !== 32'h12345678) begin nerr++; $display("FAIL pipe_rf_x5: got %h want 12345678", b_rf[5]); end
    tick();
  endtask

  task automatic test_starvation();
    do_reset();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd3, 32'h0000_3000 + 32'(i), 1'b0, 5'd0, 1'b1, 5'd7, 32'hdead0007);
      if (i < 4) begin
        nvec++; if ({mc_ready, pipe_stall, rf_a3} !== {1'b0, 1'b0, 5'd3}) begin
          nerr++; $display("FAIL starve_pipe%0d: got rdy=%b stall=%b a3=%0d want 0/0/3", i, mc_ready, pipe_stall, rf_a3); end
      end else begin
        nvec++; if ({mc_ready, pipe_stall, rf_a3, rf_wd3} !== {1'b1, 1'b1, 5'd7, 32'hdead0007}) begin
          nerr++; $display("FAIL starve_mc: got rdy=%b stall=%b a3=%0d wd=%h want 1/1/7/dead0007", mc_ready, pipe_stall, rf_a3, rf_wd3); end
        nvec++; if (busy_mask[7] !== 1'b1) begin nerr++; $display("FAIL starve_busy_set: got %b want 1", busy_mask[7]); end
      end
      tick();
    end
    drive(1'b1, 5'd3, 32'h0000_3004, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    nvec++; if (busy_mask[7] !== 1'b0) begin nerr++; $display("FAIL starve_busy_clr: got %b want 0", busy_mask[7]); end
    nvec++; if ({rf_we, rf_a3, pipe_stall} !== {1'b1, 5'd3, 1'b0}) begin
      nerr++; $display("FAIL starve_represent: got we=%b a3=%0d stall=%b want 1/3/0", rf_we, rf_a3, pipe_stall); end
    tick();
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 1'b0, 5'd0, 32'd0); tick();
    end
    idle();
    nvec++; if ({mc_issue_ready, dut.u_sb.out_cnt_r} !== {1'b0, 5'd4}) begin
      nerr++; $display("FAIL ovf_full: got rdy=%b cnt=%0d want 0/4", mc_issue_ready, dut.u_sb.out_cnt_r); end
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 1'b0, 5'd0, 32'd0); tick(); idle();
    nvec++; if ({dut.u_sb.err_ovf_r, dut.u_sb.out_cnt_r, busy_mask[10]} !== {1'b1, 5'd4, 1'b0}) begin
      nerr++; $display("FAIL ovf_flag: got ovf=%b cnt=%0d b10=%b want 1/4/0", dut.u_sb.err_ovf_r, dut.u_sb.out_cnt_r, busy_mask[10]); end
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 1'b1, 5'd1, 32'h11);
    nvec++; if (mc_ready !== 1'b1) begin nerr++; $display("FAIL ovf_accept: got %b want 1", mc_ready); end
    tick(); idle();
    nvec++; if ({dut.u_sb.out_cnt_r, busy_mask[11], busy_mask[1]} !== {5'd4, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL ovf_swap: got cnt=%0d b11=%b b1=%b want 4/1/0", dut.u_sb.out_cnt_r, busy_mask[11], busy_mask[1]); end
    tick();
  endtask

  task automatic test_x0_and_same_cycle();
    do_reset();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 5'd0, 32'd0); tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hbad0);
    nvec++; if ({mc_ready, rf_we} !== {1'b1, 1'b0}) begin
      nerr++; $display("FAIL x0_mc: got rdy=%b we=%b want 1/0", mc_ready, rf_we); end
    tick();
    drive(1'b1, 5'd0, 32'hbad1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    nvec++; if ({rf_we, busy_mask[0], dut.u_sb.out_cnt_r} !== {1'b0, 1'b0, 5'd0}) begin
      nerr++; $display("FAIL x0_pipe: got we=%b b0=%b cnt=%0d want 0/0/0", rf_we, busy_mask[0], dut.u_sb.out_cnt_r); end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0); tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b1, 5'd9, 32'h99); tick(); idle();
    nvec++; if ({busy_mask[9], dut.u_sb.out_cnt_r} !== {1'b1, 5'd1}) begin
      nerr++; $display("FAIL same_rd: got b9=%b cnt=%0d want 1/1", busy_mask[9], dut.u_sb.out_cnt_r); end
    tick();
  endtask

  task automatic test_random();
    logic pw, iss, mv;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      pw  = ($urandom_range(0, 99) < 60);
      iss = ($urandom_range(0, 99) < 30);
      mv  = (m_out > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 5);
      drive(pw, 5'($urandom), $urandom, iss, 5'($urandom), mv, 5'($urandom), $urandom);
      nvec++; if ({rf_we, rf_a3, rf_wd3, mc_ready, pipe_stall} !== {e_we, e_a3, e_wd, e_mcr, e_stall}) begin
        nerr++; $display("FAIL rnd_port@%0d: got we=%b a3=%0d wd=%h rdy=%b st=%b want %b/%0d/%h/%b/%b",
                         n, rf_we, rf_a3, rf_wd3, mc_ready, pipe_stall, e_we, e_a3, e_wd, e_mcr, e_stall); end
      nvec++; if ({busy_mask, mc_issue_ready, dut.u_sb.out_cnt_r, dut.u_sb.err_ovf_r} !== {m_busy, (m_out < MO), 5'(m_out), m_ovf}) begin
        nerr++; $display("FAIL rnd_state@%0d: got busy=%h rdy=%b cnt=%0d ovf=%b want %h/%b/%0d/%b",
                         n, busy_mask, mc_issue_ready, dut.u_sb.out_cnt_r, dut.u_sb.err_ovf_r, m_busy, (m_out < MO), m_out, m_ovf); end
      tick();
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(i + 20), 1'b0, 5'd0, 32'd0); tick();
    end
    drive(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 1'b1, 5'd21, 32'h21);
    rst = 1'b1; #1;
    nvec++; if ({mc_ready, rf_we, pipe_stall} !== 3'b000) begin
      nerr++; $display("FAIL rst_outputs: got rdy=%b we=%b st=%b want 0/0/0", mc_ready, rf_we, pipe_stall); end
    tick(); rst = 1'b0; idle();
    nvec++; if ({busy_mask, dut.u_sb.out_cnt_r, mc_issue_ready} !== {32'd0, 5'd0, 1'b1}) begin
      nerr++; $display("FAIL rst_state: got busy=%h cnt=%0d rdy=%b want 0/0/1", busy_mask, dut.u_sb.out_cnt_r, mc_issue_ready); end
    tick();
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin m_rf[r] = '0; b_rf[r] = '0; end
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_pipe_write();
    test_starvation();
    test_overflow();
    test_x0_and_same_cycle();
    test_random();
    test_reset_midop();
    for (int r = 1; r < 32; r++) begin
      nvec++; if (b_rf[r] !== m_rf[r]) begin nerr++; $display("FAIL regfile_x%0d: got %h want %h", r, b_rf[r], m_rf[r]); end
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
